// File: rtl/bus_arbiter.sv
// Single-beat shared-bus arbiter for load/store (M0), fetch (M1) and debug/DMA (M2)
// masters, with fetch starvation promotion and a slave-ready timeout.
module bus_arbiter #(
  parameter int unsigned AW           = 32,
  parameter int unsigned DW           = 32,
  parameter int unsigned TIMEOUT      = 15,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic          clk,
  input  logic          rst,

  input  logic          m0_req_in,
  input  logic [AW-1:0] m0_addr_in,
  input  logic [DW-1:0] m0_data_in,
  input  logic          m0_rw_in,
  output logic [1:0]    m0_select_as_out,
  output logic [DW-1:0] m0_data_out,

  input  logic          m1_req_in,
  input  logic [AW-1:0] m1_addr_in,
  input  logic [DW-1:0] m1_data_in,
  input  logic          m1_rw_in,
  output logic [1:0]    m1_select_as_out,
  output logic [DW-1:0] m1_data_out,

  input  logic          m2_req_in,
  input  logic [AW-1:0] m2_addr_in,
  input  logic [DW-1:0] m2_data_in,
  input  logic          m2_rw_in,
  output logic [1:0]    m2_select_as_out,
  output logic [DW-1:0] m2_data_out,

  output logic          s_valid_out,
  output logic [AW-1:0] s_addr_out,
  output logic [DW-1:0] s_data_out,
  output logic          s_rw_out,
  input  logic          s_ready_in,
  input  logic [DW-1:0] s_data_in,

  output logic          bus_hold_flag_out,
  output logic          timeout_out
);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;
  typedef enum logic [1:0] {
    SEL_NONE  = 2'b00,
    SEL_READ  = 2'b01,
    SEL_WRITE = 2'b10,
    SEL_ERR   = 2'b11
  } sel_t;
  typedef enum logic [1:0] {M0 = 2'd0, M1 = 2'd1, M2 = 2'd2} master_t;

  localparam logic [7:0] WAIT_LAST  = 8'(TIMEOUT - 1);
  localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIMIT);

  state_t        state, state_nxt;
  sel_t          done_mode, done_mode_nxt;
  master_t       winner, grant_id;
  logic [7:0]    wait_cnt;
  logic [3:0]    starve_cnt;
  logic [2:0]    elig;
  logic          grant, launch, capture, timeout_nxt;
  logic [AW-1:0] grant_addr;
  logic [DW-1:0] grant_data;
  logic          grant_rw;

  // The master being acknowledged in DONE still holds req for this cycle only.
  always_comb begin
    elig = {m2_req_in, m1_req_in, m0_req_in};
    if (state == DONE) begin
      case (winner)
        M0:      elig[0] = 1'b0;
        M1:      elig[1] = 1'b0;
        M2:      elig[2] = 1'b0;
        default: ;
      endcase
    end
  end

  always_comb begin
    grant    = 1'b1;
    grant_id = M0;
    if (elig[1] && starve_cnt == STARVE_MAX) grant_id = M1;
    else if (elig[0])                        grant_id = M0;
    else if (elig[2])                        grant_id = M2;
    else if (elig[1])                        grant_id = M1;
    else                                     grant    = 1'b0;
  end

  always_comb begin
    case (grant_id)
      M1: begin
        grant_addr = m1_addr_in;
        grant_data = m1_data_in;
        grant_rw   = m1_rw_in;
      end
      M2: begin
        grant_addr = m2_addr_in;
        grant_data = m2_data_in;
        grant_rw   = m2_rw_in;
      end
      default: begin
        grant_addr = m0_addr_in;
        grant_data = m0_data_in;
        grant_rw   = m0_rw_in;
      end
    endcase
  end

  always_comb begin
    state_nxt     = state;
    done_mode_nxt = done_mode;
    timeout_nxt   = 1'b0;
    launch        = 1'b0;
    capture       = 1'b0;
    case (state)
      IDLE, DONE: begin
        if (grant) begin
          state_nxt = ACCESS;
          launch    = 1'b1;
        end else begin
          state_nxt = IDLE;
        end
      end
      ACCESS: begin
        if (s_ready_in) begin
          state_nxt     = DONE;
          done_mode_nxt = s_rw_out ? SEL_WRITE : SEL_READ;
          capture       = ~s_rw_out;
        end else if (wait_cnt == WAIT_LAST) begin
          state_nxt     = DONE;
          done_mode_nxt = SEL_ERR;
          timeout_nxt   = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      done_mode   <= SEL_NONE;
      winner      <= M0;
      wait_cnt    <= '0;
      starve_cnt  <= '0;
      timeout_out <= 1'b0;
      s_addr_out  <= '0;
      s_data_out  <= '0;
      s_rw_out    <= 1'b0;
      m0_data_out <= '0;
      m1_data_out <= '0;
      m2_data_out <= '0;
    end else begin
      state       <= state_nxt;
      done_mode   <= done_mode_nxt;
      timeout_out <= timeout_nxt;

      if (launch) begin
        winner     <= grant_id;
        s_addr_out <= grant_addr;
        s_data_out <= grant_data;
        s_rw_out   <= grant_rw;
        wait_cnt   <= '0;
      end else if (state == ACCESS) begin
        wait_cnt   <= wait_cnt + 8'd1;
      end

      if (capture) begin
        case (winner)
          M0:      m0_data_out <= s_data_in;
          M1:      m1_data_out <= s_data_in;
          M2:      m2_data_out <= s_data_in;
          default: ;
        endcase
      end

      if (!m1_req_in) begin
        starve_cnt <= '0;
      end else if (launch) begin
        if (grant_id == M1)              starve_cnt <= '0;
        else if (starve_cnt != STARVE_MAX) starve_cnt <= starve_cnt + 4'd1;
      end
    end
  end

  assign s_valid_out      = (state == ACCESS);
  assign m0_select_as_out = (state == DONE && winner == M0) ? done_mode : SEL_NONE;
  assign m1_select_as_out = (state == DONE && winner == M1) ? done_mode : SEL_NONE;
  assign m2_select_as_out = (state == DONE && winner == M2) ? done_mode : SEL_NONE;

  // Only the core's own ports stall its pipeline; M2 is external.
  assign bus_hold_flag_out = (m0_req_in & ~(state == DONE && winner == M0))
                           | (m1_req_in & ~(state == DONE && winner == M1));

endmodule

// File: tb/tb_bus_arbiter.sv
// Self-checking bench for bus_arbiter: directed scenarios plus randomized traffic,
// checked every cycle against a transaction-level model of the arbiter.
module tb_bus_arbiter;
  localparam int AW           = 32;
  localparam int DW           = 32;
  localparam int TIMEOUT      = 15;
  localparam int STARVE_LIMIT = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic          req   [3];
  logic [AW-1:0] addr  [3];
  logic [DW-1:0] wdata [3];
  logic          rw    [3];
  logic          ready;
  logic [DW-1:0] sdata;

  logic [1:0]    sel0, sel1, sel2;
  logic [DW-1:0] dout0, dout1, dout2;
  logic [1:0]    sel_a  [3];
  logic [DW-1:0] dout_a [3];
  logic          s_valid_out, s_rw_out, bus_hold_flag_out, timeout_out;
  logic [AW-1:0] s_addr_out;
  logic [DW-1:0] s_data_out;

  assign sel_a[0] = sel0;   assign sel_a[1] = sel1;   assign sel_a[2] = sel2;
  assign dout_a[0] = dout0; assign dout_a[1] = dout1; assign dout_a[2] = dout2;

  bus_arbiter #(.AW(AW), .DW(DW), .TIMEOUT(TIMEOUT), .STARVE_LIMIT(STARVE_LIMIT)) dut (
    .clk(clk), .rst(rst),
    .m0_req_in(req[0]), .m0_addr_in(addr[0]), .m0_data_in(wdata[0]), .m0_rw_in(rw[0]),
    .m0_select_as_out(sel0), .m0_data_out(dout0),
    .m1_req_in(req[1]), .m1_addr_in(addr[1]), .m1_data_in(wdata[1]), .m1_rw_in(rw[1]),
    .m1_select_as_out(sel1), .m1_data_out(dout1),
    .m2_req_in(req[2]), .m2_addr_in(addr[2]), .m2_data_in(wdata[2]), .m2_rw_in(rw[2]),
    .m2_select_as_out(sel2), .m2_data_out(dout2),
    .s_valid_out(s_valid_out), .s_addr_out(s_addr_out), .s_data_out(s_data_out),
    .s_rw_out(s_rw_out), .s_ready_in(ready), .s_data_in(sdata),
    .bus_hold_flag_out(bus_hold_flag_out), .timeout_out(timeout_out)
  );

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  // Model: phase 0 = idle, 1 = access in flight, 2 = completion cycle.
  int            m_ph, m_own, m_start, m_mode, m_starve;
  bit            m_tmo;
  logic [DW-1:0] m_dout [3];
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wdata;
  logic          m_rw;

  int pulse_cyc [3];
  int pulse_mode [3];
  int tmo_cyc, tmo_count;
  logic hold_snap;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
    end
  endtask

  task automatic model_reset();
    m_ph = 0; m_own = 0; m_start = 0; m_mode = 0; m_starve = 0; m_tmo = 0;
    for (int i = 0; i < 3; i++) m_dout[i] = '0;
    m_addr = '0; m_wdata = '0; m_rw = 1'b0;
  endtask

  // Advance the model across one rising edge using the inputs held during cycle cyc.
  task automatic model_step();
    int order [3] = '{0, 2, 1};
    bit el [3];
    int pick;
    bit tnext;
    if (rst) begin
      model_reset();
      return;
    end
    tnext = 1'b0;
    if (m_ph == 1) begin
      if (ready) begin
        if (!m_rw) m_dout[m_own] = sdata;
        m_mode = m_rw ? 2 : 1;
        m_ph   = 2;
      end else if (cyc - m_start + 1 == TIMEOUT) begin
        m_mode = 3;
        m_ph   = 2;
        tnext  = 1'b1;
      end
      if (!req[1]) m_starve = 0;
    end else begin
      for (int i = 0; i < 3; i++) el[i] = req[i] && !(m_ph == 2 && m_own == i);
      pick = -1;
      if (el[1] && m_starve == STARVE_LIMIT) pick = 1;
      else for (int k = 0; k < 3; k++) if (pick < 0 && el[order[k]]) pick = order[k];
      if (!req[1] || pick == 1) m_starve = 0;
      else if (pick >= 0 && m_starve < STARVE_LIMIT) m_starve++;
      if (pick >= 0) begin
        m_own   = pick;
        m_addr  = addr[pick];
        m_wdata = wdata[pick];
        m_rw    = rw[pick];
        m_start = cyc + 1;
        m_ph    = 1;
      end else begin
        m_ph = 0;
      end
    end
    m_tmo = tnext;
  endtask

  task automatic compare();
    int exp_sel;
    bit exp_hold;
    for (int i = 0; i < 3; i++) begin
      exp_sel = (m_ph == 2 && m_own == i) ? m_mode : 0;
      check($sformatf("m%0d_select", i), 64'(sel_a[i]), 64'(exp_sel));
      check($sformatf("m%0d_data", i), 64'(dout_a[i]), 64'(m_dout[i]));
    end
    check("s_valid", 64'(s_valid_out), 64'(m_ph == 1));
    check("s_addr", 64'(s_addr_out), 64'(m_addr));
    check("s_data", 64'(s_data_out), 64'(m_wdata));
    check("s_rw", 64'(s_rw_out), 64'(m_rw));
    check("timeout", 64'(timeout_out), 64'(m_tmo));
    exp_hold = (req[0] && !(m_ph == 2 && m_own == 0)) || (req[1] && !(m_ph == 2 && m_own == 1));
    check("bus_hold", 64'(bus_hold_flag_out), 64'(exp_hold));
  endtask

  // One clock: model and DUT advance, outputs compared mid-cycle, acked masters drop req.
  task automatic tick();
    @(posedge clk);
    model_step();
    cyc++;
    @(negedge clk);
    compare();
    hold_snap = bus_hold_flag_out;
    for (int i = 0; i < 3; i++) begin
      if (sel_a[i] != 2'b00) begin
        pulse_cyc[i]  = cyc;
        pulse_mode[i] = int'(sel_a[i]);
      end
      if (m_ph == 2 && m_own == i) req[i] = 1'b0;
    end
    if (timeout_out) begin
      tmo_cyc = cyc;
      tmo_count++;
    end
  endtask

  task automatic clear_marks();
    for (int i = 0; i < 3; i++) begin
      pulse_cyc[i]  = -1;
      pulse_mode[i] = 0;
    end
    tmo_cyc   = -1;
    tmo_count = 0;
  endtask

  task automatic set_req(input int m, input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d);
    req[m] = 1'b1; rw[m] = w; addr[m] = a; wdata[m] = d;
  endtask

  int t0;
  int dead;

  initial begin
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      req[i] = 1'b0; addr[i] = '0; wdata[i] = '0; rw[i] = 1'b0;
    end
    ready = 1'b0; sdata = '0;
    model_reset();
    clear_marks();
    repeat (3) tick();
    check("reset_valid", 64'(s_valid_out), 64'(0));
    check("reset_addr", 64'(s_addr_out), 64'(0));
    @(negedge clk);
    rst = 1'b0;

    // Single zero-wait read
    clear_marks();
    ready = 1'b1; sdata = 32'hDEADBEEF;
    set_req(0, 1'b0, 32'h100, 32'h0);
    t0 = cyc;
    #1 check("t1_hold_c0", 64'(bus_hold_flag_out), 64'(1));
    tick();
    check("t1_valid_c1", 64'(s_valid_out), 64'(1));
    check("t1_addr_c1", 64'(s_addr_out), 64'(32'h100));
    check("t1_hold_c1", 64'(hold_snap), 64'(1));
    tick();
    check("t1_sel_c2", 64'(sel0), 64'(1));
    check("t1_data", 64'(dout0), 64'(32'hDEADBEEF));
    check("t1_hold_c2", 64'(hold_snap), 64'(0));
    repeat (2) tick();

    // Simultaneous requests: M0, then M2, then M1
    clear_marks();
    sdata = 32'hA5A50002;
    set_req(0, 1'b1, 32'h200, 32'h11);
    set_req(1, 1'b0, 32'h300, 32'h0);
    set_req(2, 1'b0, 32'h400, 32'h0);
    t0 = cyc;
    repeat (8) tick();
    check("t2_m0_cycle", 64'(pulse_cyc[0] - t0), 64'(2));
    check("t2_m2_cycle", 64'(pulse_cyc[2] - t0), 64'(4));
    check("t2_m1_cycle", 64'(pulse_cyc[1] - t0), 64'(6));
    check("t2_m0_mode", 64'(pulse_mode[0]), 64'(2));
    check("t2_m1_mode", 64'(pulse_mode[1]), 64'(1));

    // Starvation: M0 and M2 keep re-requesting, M1 promoted on 5th arbitration
    clear_marks();
    sdata = 32'h00000055;
    set_req(0, 1'b1, 32'h210, 32'h22);
    set_req(2, 1'b1, 32'h410, 32'h33);
    set_req(1, 1'b0, 32'h500, 32'h0);
    t0 = cyc;
    for (int k = 1; k <= 16; k++) begin
      tick();
      if (k == 8) check("t3_starve_full", 64'(dut.starve_cnt), 64'(4));
      if (pulse_cyc[1] < 0) begin
        if (!req[0]) set_req(0, 1'b1, 32'h210 + 32'(k), 32'h22);
        if (!req[2]) set_req(2, 1'b1, 32'h410 + 32'(k), 32'h33);
      end
    end
    check("t3_m1_cycle", 64'(pulse_cyc[1] - t0), 64'(10));
    check("t3_starve_clr", 64'(dut.starve_cnt), 64'(0));
    check("t3_m1_data", 64'(dout1), 64'(32'h55));

    // Timeout with ready tied low, then a normal access
    clear_marks();
    ready = 1'b0;
    set_req(2, 1'b0, 32'h600, 32'h0);
    t0 = cyc;
    repeat (18) tick();
    check("t4_err_cycle", 64'(pulse_cyc[2] - t0), 64'(16));
    check("t4_err_mode", 64'(pulse_mode[2]), 64'(3));
    check("t4_tmo_cycle", 64'(tmo_cyc - t0), 64'(16));
    check("t4_tmo_width", 64'(tmo_count), 64'(1));
    check("t4_data_kept", 64'(dout2), 64'(32'hA5A50002));
    clear_marks();
    ready = 1'b1; sdata = 32'h0BADF00D;
    set_req(2, 1'b0, 32'h604, 32'h0);
    t0 = cyc;
    repeat (3) tick();
    check("t4_next_cycle", 64'(pulse_cyc[2] - t0), 64'(2));
    check("t4_next_data", 64'(dout2), 64'(32'h0BADF00D));

    // Three wait states
    clear_marks();
    ready = 1'b0; sdata = 32'hFFFF0000;
    set_req(1, 1'b0, 32'h2A0, 32'h0);
    t0 = cyc;
    for (int k = 1; k <= 5; k++) begin
      tick();
      if (k <= 4) begin
        check("t5_valid", 64'(s_valid_out), 64'(1));
        check("t5_addr", 64'(s_addr_out), 64'(32'h2A0));
      end
      if (k == 4) begin
        ready = 1'b1; sdata = 32'h12345678;
      end
    end
    check("t5_cycle", 64'(pulse_cyc[1] - t0), 64'(5));
    check("t5_data", 64'(dout1), 64'(32'h12345678));
    tick();

    // Reset in the middle of an access
    clear_marks();
    ready = 1'b0;
    set_req(0, 1'b0, 32'h700, 32'h0);
    tick();
    check("t6_valid_pre", 64'(s_valid_out), 64'(1));
    #2 rst = 1'b1;
    #1;
    check("t6_valid_rst", 64'(s_valid_out), 64'(0));
    check("t6_addr_rst", 64'(s_addr_out), 64'(0));
    check("t6_data_rst", 64'(dout1), 64'(0));
    check("t6_sel_rst", 64'(sel0), 64'(0));
    check("t6_hold_rst", 64'(bus_hold_flag_out), 64'(1));
    tick();
    req[0] = 1'b0;
    rst = 1'b0;
    ready = 1'b1; sdata = 32'hCAFE0001;
    set_req(1, 1'b0, 32'h800, 32'h0);
    t0 = cyc;
    repeat (3) tick();
    check("t6_no_m0_pulse", 64'(pulse_cyc[0]), 64'(-1));
    check("t6_after_cycle", 64'(pulse_cyc[1] - t0), 64'(2));
    check("t6_after_data", 64'(dout1), 64'(32'hCAFE0001));

    // Randomized traffic with occasional dead-slave windows
    dead = 0;
    for (int n = 0; n < 3000 && fails < 50; n++) begin
      for (int i = 0; i < 3; i++)
        if (!req[i] && ($urandom % 4 == 0))
          set_req(i, 1'($urandom % 2), $urandom, $urandom);
      if (dead > 0) begin
        ready = 1'b0;
        dead--;
      end else begin
        if ($urandom % 200 == 0) dead = 20;
        ready = ($urandom % 10) < 7;
      end
      sdata = $urandom;
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/bus_arbiter.md
# bus_arbiter

Single-beat shared-bus arbiter and sequencer between the core's load/store port (M0), the core's instruction-fetch port (M1) and an external debug/DMA master (M2). It sits between the core boundary and the single slave-side memory bus. It selects one requester and drives the slave handshake, with a timeout. It returns the per-master select mode plus read data, and raises the core's bus hold flag while a core request is outstanding.

## Interface
Parameters:
- AW, 32, address width
- DW, 32, data width
- TIMEOUT, 15, max cycles waiting on s_ready_in before abort (1..255)
- STARVE_LIMIT, 4, consecutive lost arbitrations after which M1 is promoted (1..15)

Select mode encoding (2 bits): NONE=2'b00, READ=2'b01, WRITE=2'b10, ERR=2'b11.

Ports (x = 0,1,2):
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-high reset
- mx_req_in  in  1  request; held high until mx_select_as_out != NONE
- mx_addr_in  in  AW  address
- mx_data_in  in  DW  write data
- mx_rw_in  in  1  1 = write, 0 = read
- mx_select_as_out  out  2  completion pulse with the mode; NONE otherwise
- mx_data_out  out  DW  read data, valid while select is READ, held afterwards
- s_valid_out  out  1  slave access valid
- s_addr_out  out  AW  registered address
- s_data_out  out  DW  registered write data
- s_rw_out  out  1  registered direction
- s_ready_in  in  1  slave accepts/completes the access this cycle
- s_data_in  in  DW  slave read data, valid with s_ready_in
- bus_hold_flag_out  out  1  stall request to the core pipeline
- timeout_out  out  1  one-cycle pulse on abort

## Operation
- States: IDLE, ACCESS, DONE.
- Arbitration is evaluated in IDLE and DONE. Fixed priority is M0 > M2 > M1.
- Promotion: if starve_cnt == STARVE_LIMIT and m1_req_in is high, M1 wins over all. starve_cnt then clears.
- starve_cnt increments when m1_req_in is high and another master wins. It clears when M1 wins or m1_req_in is low. It saturates at STARVE_LIMIT.
- On a win: latch the winner id, addr, data and rw into the s_* registers, clear wait_cnt, then go to ACCESS.
- ACCESS: s_valid_out = 1.
  - If s_ready_in is high: for a read, capture s_data_in into the winner's data_out register; go to DONE with done_mode = READ or WRITE.
  - If s_ready_in is low and wait_cnt == TIMEOUT-1: go to DONE with done_mode = ERR and pulse timeout_out. The winner's data_out is unchanged.
  - Otherwise wait_cnt increments.
- DONE: the winner's select_as_out = done_mode for exactly this cycle. The winner's req_in is ignored for arbitration in this cycle, since the master drops it on the next edge. Go to ACCESS if another request wins, else IDLE.
- A master that drops req_in while in ACCESS does not abort the access. The access completes and the DONE pulse is still issued.
- bus_hold_flag_out (combinational) = (m0_req_in & ~(winner==M0 & DONE)) | (m1_req_in & ~(winner==M1 & DONE)). M2 never holds the core.
- s_addr_out, s_data_out and s_rw_out are stable for the whole ACCESS.

## Timing
- Reset values:
  - state = IDLE; all select outputs NONE.
  - all mx_data_out = 0; s_valid_out, s_addr_out, s_data_out, s_rw_out = 0.
  - timeout_out = 0; counters = 0.
  - bus_hold_flag_out follows the request inputs.
- Reset asserted mid-ACCESS drops s_valid_out immediately (asynchronous). No DONE pulse is issued.
- Request sampled at edge N: ACCESS in cycle N+1. With a zero-wait slave, ready arrives in N+1 and the DONE pulse is in cycle N+2. Minimum latency is 2 cycles.
- Back-to-back: DONE → ACCESS without IDLE. Throughput is one access per 2 cycles.
- An access with k wait cycles gives DONE at N+2+k. A timeout gives DONE at N+1+TIMEOUT with ERR.
- s_ready_in outside ACCESS is ignored.

## Test plan
- Single read, zero-wait: m0 read addr 0x100 with slave data 0xDEADBEEF. Required: s_valid_out in cycle 1; m0_select_as_out = READ in cycle 2; m0_data_out = 0xDEADBEEF; hold high for cycles 0–1 and low in cycle 2.
- Simultaneous m0 write, m1 read and m2 read at cycle 0. Required grant order: M0, then M2, then M1. DONE pulses at cycles 2, 4 and 6.
- Starvation: m0 requests continuously and m1 requests from cycle 0, with STARVE_LIMIT=4. Required: M1 is granted on the 5th arbitration; starve_cnt returns to 0.
- Timeout, TIMEOUT=15, s_ready_in tied low. Required: m2_select_as_out = ERR in cycle 16; timeout_out is a one-cycle pulse; m2_data_out is unchanged; the next access works.
- Wait states: 3 low-ready cycles, then ready with data 0x12345678. Required: s_addr_out is stable for all 4 ACCESS cycles; READ pulse in cycle 5.
- Reset asserted mid-ACCESS. Required: all outputs at reset values on the same edge; no select pulse; a new request after deassertion completes normally.
